// File: rtl/trng_pkg.sv
// ---------------------------------------------------------------------------
// trng_pkg
// Shared definitions for the ring-oscillator entropy source:
//   - trng_state_t : control FSM states (IDLE, WARMUP, RUN, HOLD)
//   - cnt_w        : width of a counter that runs 0..n-1
//   - cnt_w_incl   : width of a counter that must also hold the value n
//   - VN_EMIT_*    : von Neumann pair codes {first, second} that yield a bit
// ---------------------------------------------------------------------------
package trng_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2,
    HOLD   = 2'd3
  } trng_state_t;

  // Width for a counter spanning 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width for a counter spanning 0..n.
  function automatic int cnt_w_incl(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Pair (a,b) with a != b emits a; equal pairs are discarded.
  localparam logic [1:0] VN_EMIT_ONE  = 2'b10;
  localparam logic [1:0] VN_EMIT_ZERO = 2'b01;

endpackage

// File: rtl/ro_channel.sv
// ---------------------------------------------------------------------------
// ro_channel
// One gated ring oscillator. In synthesis builds (SYNTHESIS defined) this is a
// NAND-gated inverter chain of STAGES inversions kept intact by keep
// attributes; it free-runs while enable=1 and parks when enable=0. In
// simulation the oscillator is modelled as a registered $urandom bit.
//
// Ports:
//   clk      in  1  clock for the simulation model
//   reset    in  1  synchronous active-high reset (simulation model)
//   enable   in  1  oscillator gate
//   rand_bit out 1  asynchronous oscillator output (synchronised by the user)
// ---------------------------------------------------------------------------
module ro_channel #(
  parameter int STAGES = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic rand_bit
);

`ifdef SYNTHESIS
  // NAND gate plus STAGES-1 inverters gives an odd inversion count.
  (* keep = "true" *) logic [STAGES-1:0] chain;

  assign chain[0] = ~(chain[STAGES-1] & enable);

  genvar i;
  for (i = 1; i < STAGES; i++) begin : g_inv
    assign chain[i] = ~chain[i-1];
  end

  assign rand_bit = chain[STAGES-1];
`else
  logic osc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      osc_q <= 1'b0;
    end else if (enable) begin
      osc_q <= 1'($urandom);
    end
  end

  assign rand_bit = osc_q;
`endif

endmodule

// File: rtl/trng_noise_source.sv
// ---------------------------------------------------------------------------
// trng_noise_source
// Multi-channel ring-oscillator entropy source. CHANNELS oscillators are
// XORed into one raw bit (or test_bit replaces it in test_mode), passed
// through a 2-flop synchroniser, sampled every SAMPLE_DIV clocks, debiased
// by a von Neumann corrector and packed MSB-first into WIDTH-bit words.
//
// Optional feature: define TRNG_HEALTH_TEST_EN to add a repetition-count
// health test (REP_LIMIT equal consecutive samples -> sticky health_fail).
//
// Handshake: out_valid rises with a complete word in out_data; out_data is
// stable while out_valid=1; a word is transferred on a clock where
// out_valid && out_ready, and out_valid falls on the following cycle.
// out_ready while out_valid=0 has no effect.
//
// Ports:
//   CLOCK_50    in  1      system clock
//   reset       in  1      synchronous active-high reset
//   enable      in  1      run oscillators and pipeline; 0 = idle
//   test_mode   in  1      use test_bit as the raw bit
//   test_bit    in  1      injected raw bit
//   out_ready   in  1      consumer accepts word
//   out_data    out WIDTH  random word
//   out_valid   out 1      out_data holds a complete word
//   warm        out 1      warm-up complete, sampling active
//   health_fail out 1      sticky health-test failure
// ---------------------------------------------------------------------------
module trng_noise_source
  import trng_pkg::*;
#(
  parameter int STAGES        = 13,
  parameter int CHANNELS      = 4,
  parameter int WIDTH         = 16,
  parameter int SAMPLE_DIV    = 8,
  parameter int WARMUP_CYCLES = 1024,
  parameter int REP_LIMIT     = 32
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             enable,
  input  logic             test_mode,
  input  logic             test_bit,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             warm,
  output logic             health_fail
);

  localparam int PW = cnt_w(SAMPLE_DIV);
  localparam int BW = cnt_w(WIDTH);
  localparam int WW = cnt_w_incl(WARMUP_CYCLES);

  localparam logic [PW-1:0] PRESC_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);
  localparam logic [WW-1:0] WARM_LAST  = WW'(WARMUP_CYCLES - 1);

  // ---------------- oscillators and raw path ----------------
  logic [CHANNELS-1:0] ch_bit;

  genvar g;
  for (g = 0; g < CHANNELS; g++) begin : g_ch
    ro_channel #(.STAGES(STAGES)) u_ro (
      .clk      (CLOCK_50),
      .reset    (reset),
      .enable   (enable),
      .rand_bit (ch_bit[g])
    );
  end

  logic raw_bit;
  logic sync1;
  logic sync2;

  assign raw_bit = test_mode ? test_bit : ^ch_bit;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw_bit;
      sync2 <= sync1;
    end
  end

  // ---------------- state and datapath registers ----------------
  trng_state_t       state;
  trng_state_t       state_next;
  logic              enter_run;
  logic [PW-1:0]     presc;
  logic              pair_phase;   // 0 = next strobe is first of a pair
  logic              pair_a;
  logic [WIDTH-1:0]  acc;
  logic [BW-1:0]     bit_cnt;
  logic [WW-1:0]     warm_cnt;
  logic              strobe;
  logic              clean_valid;
  logic              clean_bit;
  logic              word_done;
  logic              hf_block;

  assign strobe    = (state == RUN) && (presc == PRESC_LAST);
  assign word_done = clean_valid && (bit_cnt == BIT_LAST);
  assign warm      = (state == RUN) || (state == HOLD);

  // Von Neumann decode on the second strobe of each pair.
  always_comb begin
    clean_valid = 1'b0;
    clean_bit   = 1'b0;
    if (strobe && pair_phase && !hf_block) begin
      case ({pair_a, sync2})
        VN_EMIT_ONE: begin
          clean_valid = 1'b1;
          clean_bit   = 1'b1;
        end
        VN_EMIT_ZERO: begin
          clean_valid = 1'b1;
          clean_bit   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    enter_run  = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = WARMUP;
      end
      WARMUP: begin
        if (test_mode || (warm_cnt == WARM_LAST)) begin
          state_next = RUN;
          enter_run  = 1'b1;
        end
      end
      RUN: begin
        if (word_done) state_next = HOLD;
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          state_next = RUN;
          enter_run  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Dropping enable overrides everything and discards any partial word.
    if (!enable) begin
      state_next = IDLE;
      enter_run  = 1'b0;
    end
  end

  // ---------------- sampler, corrector, packer ----------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      presc      <= '0;
      pair_phase <= 1'b0;
      pair_a     <= 1'b0;
      acc        <= '0;
      bit_cnt    <= '0;
      warm_cnt   <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
    end else if (!enable) begin
      presc      <= '0;
      pair_phase <= 1'b0;
      acc        <= '0;
      bit_cnt    <= '0;
      warm_cnt   <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (state == WARMUP) begin
        warm_cnt <= warm_cnt + 1'b1;
      end else begin
        warm_cnt <= '0;
      end

      // Prescaler and pair phase restart on every entry to RUN; both are
      // frozen outside RUN because strobe is only asserted in RUN.
      if (enter_run) begin
        presc      <= '0;
        pair_phase <= 1'b0;
      end else if (strobe) begin
        presc      <= '0;
        pair_phase <= ~pair_phase;
        if (!pair_phase) pair_a <= sync2;
      end else if (state == RUN) begin
        presc <= presc + 1'b1;
      end

      if (word_done) begin
        out_data  <= {acc[WIDTH-2:0], clean_bit};
        out_valid <= 1'b1;
        acc       <= '0;
        bit_cnt   <= '0;
      end else if (clean_valid) begin
        acc     <= {acc[WIDTH-2:0], clean_bit};
        bit_cnt <= bit_cnt + 1'b1;
      end

      if ((state == HOLD) && out_valid && out_ready) begin
        out_valid <= 1'b0;
        acc       <= '0;
        bit_cnt   <= '0;
      end

      if (hf_block) out_valid <= 1'b0;
    end
  end

  // ---------------- optional health test ----------------
`ifdef TRNG_HEALTH_TEST_EN
  localparam int RW = cnt_w_incl(REP_LIMIT);
  localparam logic [RW-1:0] REP_TRIP = RW'(REP_LIMIT - 1);
  localparam logic [RW-1:0] REP_MAX  = RW'(REP_LIMIT);

  logic [RW-1:0] rep_cnt;   // length of the current run of equal samples
  logic          rep_last;
  logic          hf_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rep_cnt  <= '0;
      rep_last <= 1'b0;
      hf_q     <= 1'b0;
    end else if (enter_run) begin
      rep_cnt <= '0;
    end else if (strobe) begin
      if ((rep_cnt == '0) || (sync2 != rep_last)) begin
        rep_cnt  <= RW'(1);
        rep_last <= sync2;
      end else begin
        if (rep_cnt != REP_MAX) rep_cnt <= rep_cnt + 1'b1;
        if (rep_cnt == REP_TRIP) hf_q <= 1'b1;
      end
    end
  end

  assign hf_block    = hf_q;
  assign health_fail = hf_q;
`else
  assign hf_block    = 1'b0;
  assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_trng_noise_source.sv
// ---------------------------------------------------------------------------
// tb_trng_noise_source
// Directed bench for trng_noise_source with WIDTH=8, SAMPLE_DIV=4.
// Raw bits are injected through test_mode/test_bit. With RUN entered at edge
// E0, strobe k is taken at edge E(4k) and sees the test_bit value driven just
// after edge E(4k-3) (two synchroniser flops in between).
// ---------------------------------------------------------------------------
module tb_trng_noise_source;

  localparam int WIDTH = 8;
  localparam int SDIV  = 4;

  logic             CLOCK_50;
  logic             reset;
  logic             enable;
  logic             test_mode;
  logic             test_bit;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             warm;
  logic             health_fail;

  int vectors;
  int miscompares;

  logic smp_q[$];

  trng_noise_source #(
    .STAGES        (13),
    .CHANNELS      (4),
    .WIDTH         (WIDTH),
    .SAMPLE_DIV    (SDIV),
    .WARMUP_CYCLES (1024),
    .REP_LIMIT     (32)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .enable      (enable),
    .test_mode   (test_mode),
    .test_bit    (test_bit),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .warm        (warm),
    .health_fail (health_fail)
  );

  // ---------------- clock ----------------
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset     = 1'b1;
    enable    = 1'b0;
    test_mode = 1'b1;
    test_bit  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
  endtask

  // Called #1 after an edge with the DUT in IDLE; returns #1 after E0.
  task automatic start_run(input string name);
    enable = 1'b1;
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #1;
    vectors++;
    if (warm !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_warm: warm=%b expected=1", name, warm);
    end
  endtask

  // Append one clean bit as a von Neumann pair: 1 -> (1,0), 0 -> (0,1).
  task automatic push_pairs(input logic [WIDTH-1:0] bits_v);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      smp_q.push_back(bits_v[i]);
      smp_q.push_back(~bits_v[i]);
    end
  endtask

  // Feeds smp_q one value per strobe; flags out_valid before the last edge.
  task automatic feed(output bit early);
    int n_str;
    n_str = smp_q.size();
    early = 1'b0;
    for (int n = 1; n <= SDIV * n_str; n++) begin
      @(posedge CLOCK_50);
      #1;
      if ((n < SDIV * n_str) && (out_valid !== 1'b0)) early = 1'b1;
      if (((n - 1) % SDIV) == 0) test_bit = smp_q[(n - 1) / SDIV];
    end
    smp_q.delete();
  endtask

  // Called #1 after an edge with out_valid=1; returns #1 after the accept edge.
  task automatic accept_word(input string name);
    out_ready = 1'b1;
    @(posedge CLOCK_50);
    #1;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_accept: out_valid=%b expected=0", name, out_valid);
    end
  endtask

  task automatic check_word(input string name, input bit early, input logic [WIDTH-1:0] exp);
    vectors++;
    if (early) begin
      miscompares++;
      $display("FAIL %s_early: out_valid=1 before strobe %0d, expected 0", name, 2 * WIDTH);
    end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_valid: out_valid=%b expected=1", name, out_valid);
    end
    vectors++;
    if (out_data !== exp) begin
      miscompares++;
      $display("FAIL %s_data: out_data=%h expected=%h", name, out_data, exp);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset     = 1'b1;
    enable    = 1'b1;
    test_mode = 1'b0;
    test_bit  = 1'b0;
    out_ready = 1'b0;
    repeat (5) @(posedge CLOCK_50);
    #1;
    vectors++;
    if (out_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data: out_data=%h expected=00", out_data);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: out_valid=%b expected=0", out_valid);
    end
    vectors++;
    if (warm !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_warm: warm=%b expected=0", warm);
    end
    vectors++;
    if (health_fail !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_health: health_fail=%b expected=0", health_fail);
    end
    reset = 1'b0;
    for (int k = 1; k <= 1025; k++) begin
      @(posedge CLOCK_50);
      #1;
      if (k == 1024) begin
        vectors++;
        if (warm !== 1'b0) begin
          miscompares++;
          $display("FAIL warmup_early: warm=%b at clock 1024 expected=0", warm);
        end
      end
      if (k == 1025) begin
        vectors++;
        if (warm !== 1'b1) begin
          miscompares++;
          $display("FAIL warmup_done: warm=%b at clock 1025 expected=1", warm);
        end
      end
    end
  endtask

  task automatic test_word_ones();
    bit early;
    do_reset();
    start_run("ones");
    push_pairs(8'hFF);
    feed(early);
    check_word("ones", early, 8'hFF);
  endtask

  task automatic test_hold();
    for (int i = 0; i < 100; i++) begin
      @(posedge CLOCK_50);
      #1;
      test_bit = i[1];
      vectors++;
      if ((out_valid !== 1'b1) || (out_data !== 8'hFF)) begin
        miscompares++;
        $display("FAIL hold_stable: cycle %0d out_valid=%b out_data=%h expected 1/ff",
                 i, out_valid, out_data);
      end
    end
    accept_word("hold");
  endtask

  task automatic test_discard();
    bit early;
    for (int i = 0; i < 50; i++) smp_q.push_back(1'b1);
    push_pairs(8'h00);
    feed(early);
    check_word("discard", early, 8'h00);
    accept_word("discard");
  endtask

  task automatic test_back_to_back();
    bit early;
    push_pairs(8'hB2);
    feed(early);
    check_word("b2b", early, 8'hB2);
    accept_word("b2b");
  endtask

  task automatic test_enable_drop();
    bit early;
    // three clean ones plus the first half of a pair
    for (int i = 0; i < 3; i++) begin
      smp_q.push_back(1'b1);
      smp_q.push_back(1'b0);
    end
    smp_q.push_back(1'b0);
    feed(early);
    enable = 1'b0;
    @(posedge CLOCK_50);
    #1;
    vectors++;
    if (warm !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_warm: warm=%b expected=0", warm);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_valid: out_valid=%b expected=0", out_valid);
    end
    vectors++;
    if (out_data !== 8'hB2) begin
      miscompares++;
      $display("FAIL drop_keep: out_data=%h expected=b2", out_data);
    end
    start_run("restart");
    push_pairs(8'h55);
    feed(early);
    check_word("restart", early, 8'h55);
    accept_word("restart");
  endtask

`ifdef TRNG_HEALTH_TEST_EN
  task automatic test_health();
    bit early;
    do_reset();
    test_bit = 1'b0;
    start_run("health");
    for (int i = 0; i < 31; i++) smp_q.push_back(1'b0);
    feed(early);
    vectors++;
    if (health_fail !== 1'b0) begin
      miscompares++;
      $display("FAIL health_31: health_fail=%b expected=0", health_fail);
    end
    smp_q.push_back(1'b0);
    feed(early);
    vectors++;
    if (health_fail !== 1'b1) begin
      miscompares++;
      $display("FAIL health_32: health_fail=%b expected=1", health_fail);
    end
    push_pairs(8'hA5);
    feed(early);
    vectors++;
    if ((health_fail !== 1'b1) || (out_valid !== 1'b0) || early) begin
      miscompares++;
      $display("FAIL health_sticky: health_fail=%b out_valid=%b early=%b expected 1/0/0",
               health_fail, out_valid, early);
    end
    do_reset();
    vectors++;
    if (health_fail !== 1'b0) begin
      miscompares++;
      $display("FAIL health_reset: health_fail=%b expected=0", health_fail);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_word_ones();
    test_hold();
    test_discard();
    test_back_to_back();
    test_enable_drop();
`ifdef TRNG_HEALTH_TEST_EN
    test_health();
`else
    vectors++;
    if (health_fail !== 1'b0) begin
      miscompares++;
      $display("FAIL health_tied: health_fail=%b expected=0", health_fail);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
